apb_bridge: RTL and testbench
=============================

APB_BRIDGE -- requirements
Module: apb_bridge

Interface
REQ-001 The module SHALL take parameter ADDR_WIDTH, default 32, meaning the address width.
REQ-002 The module SHALL take parameter DATA_WIDTH, default 64, meaning the data width; it must be a multiple of 8.
REQ-003 The module SHALL take parameter DEC_NUMBER, default 16, meaning the slave count (1..32, need not be a power of 2).
REQ-004 The module SHALL take parameter DEC_LSB, default 12, meaning the lowest address bit of the slave index field.
REQ-005 The module SHALL take parameter TIMEOUT, default 256, meaning the maximum ACCESS cycles; 0 disables the timeout.
REQ-006 The module SHALL have one clock and a synchronous, active-high reset: pclk input 1, the clock; preset input 1, the synchronous active-high reset.
REQ-007 The host port SHALL be: req_valid in 1; req_ready out 1; req_addr in ADDR_WIDTH; req_write in 1; req_wdata in DATA_WIDTH; req_wstrb in DATA_WIDTH/8.
REQ-008 The response port SHALL be: rsp_valid out 1; rsp_ready in 1; rsp_rdata out DATA_WIDTH; rsp_err out 1.
REQ-009 The APB port SHALL be: paddr out ADDR_WIDTH; pselx out DEC_NUMBER; penable out 1; pwrite out 1; pwdata out DATA_WIDTH; pstrb out DATA_WIDTH/8.
REQ-010 The APB return signals SHALL be: prdatax in DEC_NUMBER x DATA_WIDTH; preadyx in DEC_NUMBER; pslverrx in DEC_NUMBER.

Function
REQ-011 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-012 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-013 On req_valid and req_ready, the block SHALL register addr/write/wdata/wstrb and compute idx = req_addr[DEC_LSB +: $clog2(DEC_NUMBER)] (idx = 0 when DEC_NUMBER = 1).
REQ-014 If idx < DEC_NUMBER, the FSM SHALL go IDLE->SETUP; otherwise it SHALL go IDLE->RESP with rsp_err = 1 and rsp_rdata = 0, with no pselx bit ever asserted.
REQ-015 In SETUP, the block SHALL drive pselx = one-hot(idx) and penable = 0, and SHALL then go to ACCESS unconditionally after one cycle.
REQ-016 In ACCESS, the block SHALL drive pselx = one-hot(idx) and penable = 1, and SHALL hold paddr/pwrite/pwdata/pstrb stable from SETUP through ACCESS.
REQ-017 In ACCESS, when preadyx[idx] = 1, the block SHALL capture rsp_rdata = pwrite ? 0 : prdatax[idx] and rsp_err = pslverrx[idx], then go to RESP.
REQ-018 The ACCESS cycle counter SHALL start at 1 on the first ACCESS cycle.
REQ-019 If TIMEOUT != 0, the counter reaches TIMEOUT and preadyx[idx] = 0, the block SHALL abort to RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-020 If preadyx[idx] = 1 in the same cycle as the timeout, the block SHALL take the ready response; ready has priority.
REQ-021 Only preadyx[idx], prdatax[idx] and pslverrx[idx] SHALL be observed; all other slaves' return signals SHALL be ignored.
REQ-022 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready; pselx and penable SHALL be 0.
REQ-023 On rsp_valid and rsp_ready, the FSM SHALL go to IDLE, so a new request can be accepted on the next cycle.
REQ-024 Minimum latency SHALL be: zero-wait write accepted at cycle 0 -> rsp_valid at cycle 3 (SETUP at 1, ACCESS at 2, RESP at 3); each wait state SHALL add 1 cycle.
REQ-025 An out-of-range request SHALL produce rsp_valid at cycle 1.
REQ-026 In IDLE, paddr/pwrite/pwdata/pstrb SHALL keep their last values, so no toggling occurs when the bus is not selected.
REQ-027 pstrb SHALL be forced to 0 for reads.
REQ-028 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate without wrapping.

Reset
REQ-029 While preset = 1 at a pclk edge, the block SHALL set state = IDLE, pselx = 0, penable = 0, paddr = 0, pwrite = 0, pwdata = 0, pstrb = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 and the counter = 0.
REQ-030 Reset asserted mid-transfer SHALL drop pselx/penable on the next edge with no response issued; the slave is left to tolerate an aborted ACCESS.
REQ-031 req_ready SHALL be 0 while preset = 1.

Structure
REQ-032 Package apb_pkg SHALL hold the state enum apb_state_t {IDLE, SETUP, ACCESS, RESP} and the localparams for index and strobe widths.
REQ-033 One sub-module apb_decoder SHALL take idx and produce the one-hot select plus a valid flag; it SHALL be combinational.
REQ-034 All outputs SHALL be registered except req_ready, which SHALL be decoded from state.

Verification
REQ-035 Write to 0x0000_3010, slave 3 zero-wait -> pselx = 0x0008 with penable=0 at cycle 1, penable=1 at cycle 2, rsp_valid at cycle 3 with rsp_err=0.
REQ-036 Read from slave 0, preadyx held low 4 cycles then high with prdata 0xDEAD_BEEF_0123_4567 -> rsp_rdata equals that value, rsp_valid at cycle 7, pstrb=0.
REQ-037 With DEC_NUMBER=10, request with idx=12 -> rsp_valid at cycle 1, rsp_err=1, pselx never nonzero.
REQ-038 With TIMEOUT=8, slave never ready -> abort after 8 ACCESS cycles, rsp_err=1, rsp_rdata=0; with pready on cycle 8 -> normal response.
REQ-039 rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; back-to-back request accepted the cycle after the handshake.
REQ-040 preset pulsed during ACCESS -> next edge all outputs at reset values, req_ready=1 after release, no rsp_valid.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and width helpers for the APB bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MIN_W  = 1;

    // Slave index width; a single-slave bus still needs a one-bit register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : MIN_W;
    endfunction

    // One strobe bit per data byte.
    function automatic int unsigned strb_width(input int unsigned dw);
        return dw / BYTE_W;
    endfunction

    // Timeout counter must hold TIMEOUT itself.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t > 0) ? $clog2(t + 1) : MIN_W;
    endfunction

endpackage

// File: rtl/apb_decoder.sv
// Combinational slave index decoder: one-hot select plus in-range flag.
module apb_decoder
    import apb_pkg::*;
#(
    parameter int unsigned DEC_NUMBER = 16,
    parameter int unsigned IDX_W      = idx_width(DEC_NUMBER)
) (
    input  logic [IDX_W-1:0]      idx,
    output logic [DEC_NUMBER-1:0] sel,
    output logic                  valid
);

    // Only indices below DEC_NUMBER light a select bit.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < DEC_NUMBER; i++) begin
            sel[i] = (idx == IDX_W'(i));
        end
        valid = |sel;
    end

endmodule

// File: rtl/apb_bridge.sv
// Single-outstanding host request to APB bridge with address decode and timeout.
module apb_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEC_NUMBER = 16,
    parameter int unsigned DEC_LSB    = 12,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                                 pclk,
    input  logic                                 preset,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    input  logic                                 req_write,
    input  logic [DATA_WIDTH-1:0]                req_wdata,
    input  logic [DATA_WIDTH/8-1:0]              req_wstrb,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [DATA_WIDTH-1:0]                rsp_rdata,
    output logic                                 rsp_err,
    output logic [ADDR_WIDTH-1:0]                paddr,
    output logic [DEC_NUMBER-1:0]                pselx,
    output logic                                 penable,
    output logic                                 pwrite,
    output logic [DATA_WIDTH-1:0]                pwdata,
    output logic [DATA_WIDTH/8-1:0]              pstrb,
    input  logic [DEC_NUMBER-1:0][DATA_WIDTH-1:0] prdatax,
    input  logic [DEC_NUMBER-1:0]                preadyx,
    input  logic [DEC_NUMBER-1:0]                pslverrx
);

    localparam int unsigned STRB_W  = strb_width(DATA_WIDTH);
    localparam int unsigned IDX_W   = idx_width(DEC_NUMBER);
    localparam int unsigned FIELD_W = $clog2(DEC_NUMBER);
    localparam int unsigned CNT_W   = cnt_width(TIMEOUT);

    apb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, req_idx;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DEC_NUMBER-1:0]   req_sel, pselx_d;
    logic                    req_hit, penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_d, rsp_rdata_d;
    logic [STRB_W-1:0]       pstrb_d;
    logic                    sel_ready, sel_err, timed_out;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    // Slave index field; a single-slave bus always targets slave 0.
    if (FIELD_W == 0) begin : g_single
        assign req_idx = '0;
    end else begin : g_field
        assign req_idx = req_addr[DEC_LSB +: IDX_W];
    end

    apb_decoder #(
        .DEC_NUMBER (DEC_NUMBER),
        .IDX_W      (IDX_W)
    ) u_dec (
        .idx   (req_idx),
        .sel   (req_sel),
        .valid (req_hit)
    );

    assign req_ready = (state_q == IDLE) && !preset;

    // Only the addressed slave's return signals are observed.
    assign sel_ready = preadyx[idx_q];
    assign sel_err   = pslverrx[idx_q];
    assign sel_rdata = prdatax[idx_q];
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    // Next-state and next-output decode; everything holds unless changed.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr;
        pwrite_d    = pwrite;
        pwdata_d    = pwdata;
        pstrb_d     = pstrb;
        pselx_d     = pselx;
        penable_d   = penable;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    pstrb_d  = req_write ? req_wstrb : '0;
                    idx_d    = req_idx;
                    if (req_hit) begin
                        state_d = SETUP;
                        pselx_d = req_sel;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = CNT_W'(1);
            end
            ACCESS: begin
                if (sel_ready || timed_out) begin
                    state_d     = RESP;
                    pselx_d     = '0;
                    penable_d   = 1'b0;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_ready ? sel_err : 1'b1;
                    rsp_rdata_d = (sel_ready && !pwrite) ? sel_rdata : '0;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset returns every output to zero.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            pselx     <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            paddr     <= paddr_d;
            pwrite    <= pwrite_d;
            pwdata    <= pwdata_d;
            pstrb     <= pstrb_d;
            pselx     <= pselx_d;
            penable   <= penable_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_apb_bridge.sv
// Scoreboard bench for apb_bridge with a randomized APB slave model.
module tb_apb_bridge;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 64;
    localparam int unsigned SW  = 8;
    localparam int unsigned N   = 10;
    localparam int unsigned LSB = 12;
    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic preset;
    logic req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic [N-1:0]  pselx;
    logic penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [N-1:0][DW-1:0] prdatax;
    logic [N-1:0] preadyx, pslverrx;

    apb_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEC_NUMBER (N),
        .DEC_LSB    (LSB),
        .TIMEOUT    (TMO)
    ) dut (
        .pclk      (clk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pselx     (pselx),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdatax   (prdatax),
        .preadyx   (preadyx),
        .pslverrx  (pslverrx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int unsigned   due;
        int unsigned   hold;
    } exp_t;

    exp_t exp_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned hs_cyc  = 0;
    bit          mon_busy = 1'b0;

    // Slave behaviour for the transaction in flight.
    int unsigned   cfg_wait = 0;
    logic [DW-1:0] cfg_rdata = '0;
    logic          cfg_err = 1'b0;

    // Expected APB request fields for the transaction in flight.
    logic [N-1:0]  exp_sel = '0;
    logic [AW-1:0] exp_addr = '0;
    logic          exp_write = 1'b0;
    logic [DW-1:0] exp_wdata = '0;
    logic [SW-1:0] exp_strb = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: response content and latency from the bridge's rules.
    function automatic exp_t model(input logic [AW-1:0] addr, input logic wr, input int unsigned wt,
                                   input logic [DW-1:0] rd, input logic er,
                                   input int unsigned acc, input int unsigned hold);
        exp_t r;
        int unsigned idx;
        idx = (int'(addr) >>> 0) / (1 << LSB) % 16;
        idx = (addr / (32'd1 << LSB)) % 16;
        r.hold = hold;
        if (idx >= N) begin
            r.rdata = '0; r.err = 1'b1; r.due = acc + 1;
        end else if (wt >= TMO) begin
            r.rdata = '0; r.err = 1'b1; r.due = acc + 2 + TMO;
        end else begin
            r.rdata = wr ? '0 : rd; r.err = er; r.due = acc + 3 + wt;
        end
        return r;
    endfunction

    // APB slave model: addressed slave follows cfg, the rest drive noise.
    int unsigned acc_n = 0;
    always @(negedge clk) begin
        if (penable && pselx != '0) acc_n = acc_n + 1;
        else acc_n = 0;
        for (int i = 0; i < N; i++) begin
            if (pselx[i] && penable) begin
                preadyx[i]  = (acc_n > cfg_wait);
                prdatax[i]  = cfg_rdata;
                pslverrx[i] = (acc_n > cfg_wait) ? cfg_err : 1'($urandom);
            end else begin
                preadyx[i]  = 1'($urandom);
                prdatax[i]  = {$urandom, $urandom};
                pslverrx[i] = 1'($urandom);
            end
        end
    end

    // APB request monitor: select, phase and stable request fields.
    logic [N-1:0] prev_sel = '0;
    always @(negedge clk) begin
        if (pselx != '0) begin
            check("pselx", 64'(pselx), 64'(exp_sel));
            check("paddr", 64'(paddr), 64'(exp_addr));
            check("pwrite", 64'(pwrite), 64'(exp_write));
            check("pwdata", 64'(pwdata), 64'(exp_wdata));
            check("pstrb", 64'(pstrb), 64'(exp_strb));
            check("penable_phase", 64'(penable), 64'(prev_sel != '0));
        end else begin
            check("penable_unselected", 64'(penable), 64'(0));
        end
        prev_sel = pselx;
    end

    // Response monitor: pops the scoreboard whenever rsp_valid rises.
    initial begin : mon
        exp_t e;
        logic [DW-1:0] d0;
        logic          r0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding, required 0 (cycle %0d)", cyc);
                    hs_cyc = cyc;
                    rsp_ready = 1'b1;
                    @(negedge clk);
                    rsp_ready = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_latency", 64'(cyc), 64'(e.due));
                    d0 = rsp_rdata;
                    r0 = rsp_err;
                    for (int k = 0; k < int'(e.hold); k++) begin
                        @(negedge clk);
                        check("rsp_valid_hold", 64'(rsp_valid), 64'(1));
                        check("rsp_rdata_hold", rsp_rdata, d0);
                        check("rsp_err_hold", 64'(rsp_err), 64'(r0));
                        check("req_ready_hold", 64'(req_ready), 64'(0));
                    end
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    hs_cyc = cyc;
                    rsp_ready = 1'b1;
                    @(negedge clk);
                    rsp_ready = 1'b0;
                    check("rsp_valid_drop", 64'(rsp_valid), 64'(0));
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic issue(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] ws, input int unsigned wt, input logic [DW-1:0] rd,
                         input logic er, input int unsigned hold, input bit b2b, input bit expect_rsp);
        int unsigned guard;
        int unsigned idx;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_ready_wait: req_ready=0 after %0d cycles, required 1", guard);
        end else begin
            idx       = (addr / (32'd1 << LSB)) % 16;
            cfg_wait  = wt;
            cfg_rdata = rd;
            cfg_err   = er;
            exp_sel   = (idx < N) ? N'(1 << idx) : '0;
            exp_addr  = addr;
            exp_write = wr;
            exp_wdata = wd;
            exp_strb  = wr ? ws : '0;
            req_valid = 1'b1;
            req_addr  = addr;
            req_write = wr;
            req_wdata = wd;
            req_wstrb = ws;
            if (expect_rsp) exp_q.push_back(model(addr, wr, wt, rd, er, cyc, hold));
            if (b2b) check("b2b_accept_cycle", 64'(cyc), 64'(hs_cyc + 1));
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_write = 1'($urandom);
            req_wdata = {$urandom, $urandom};
            req_wstrb = SW'($urandom);
        end
    endtask

    task automatic drain();
        int unsigned g;
        g = 0;
        while ((exp_q.size() != 0 || mon_busy) && g < 300) begin
            g++;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || mon_busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d responses still outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check({tag, "_pselx"}, 64'(pselx), 64'(0));
        check({tag, "_penable"}, 64'(penable), 64'(0));
        check({tag, "_paddr"}, 64'(paddr), 64'(0));
        check({tag, "_pwrite"}, 64'(pwrite), 64'(0));
        check({tag, "_pwdata"}, pwdata, 64'(0));
        check({tag, "_pstrb"}, 64'(pstrb), 64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_rdata"}, rsp_rdata, 64'(0));
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
    endtask

    initial begin : stim
        logic [AW-1:0] a;
        int unsigned   idx;
        preset    = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        preset = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset", 64'(req_ready), 64'(1));

        // Directed cases.
        issue(32'h0000_3010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 0, 64'h0, 1'b0, 0, 1'b0, 1'b1);
        issue(32'h0000_0040, 1'b0, 64'hAAAA_0000_5555_FFFF, 8'hA5, 4, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, 1'b1, 1'b1);
        issue(32'h0000_C000, 1'b0, 64'h0, 8'h00, 0, 64'h1234, 1'b0, 0, 1'b1, 1'b1);
        issue(32'h0000_2008, 1'b0, 64'h0, 8'h00, 100, 64'hFFFF_0000_FFFF_0000, 1'b0, 0, 1'b1, 1'b1);
        issue(32'h0000_7000, 1'b0, 64'h0, 8'h00, 7, 64'h0BAD_CAFE_F00D_0007, 1'b0, 0, 1'b1, 1'b1);
        issue(32'h0000_9100, 1'b0, 64'h0, 8'h00, 1, 64'h5A5A_A5A5_1234_9876, 1'b1, 5, 1'b1, 1'b1);
        issue(32'h0000_1004, 1'b1, 64'hCAFE_BABE_0000_0001, 8'h0F, 2, 64'h0, 1'b1, 0, 1'b1, 1'b1);

        // Randomized traffic, including out-of-range and timeout cases.
        for (int t = 0; t < 60; t++) begin
            idx = $urandom_range(0, 15);
            a   = ($urandom & 32'hFFFF_0FFF) | (idx << LSB);
            issue(a, 1'($urandom), {$urandom, $urandom}, SW'($urandom), $urandom_range(0, 9),
                  {$urandom, $urandom}, 1'($urandom), $urandom_range(0, 3), 1'b1, 1'b1);
        end
        drain();

        // Reset in the middle of an ACCESS phase: no response may follow.
        issue(32'h0000_5000, 1'b0, 64'h0, 8'h00, 100, 64'h77, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("penable_before_abort", 64'(penable), 64'(1));
        preset = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");
        preset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("no_rsp_after_abort", 64'(rsp_valid), 64'(0));
            check("req_ready_after_abort", 64'(req_ready), 64'(1));
        end

        // Normal service resumes after the abort.
        issue(32'h0000_8020, 1'b0, 64'h0, 8'h00, 0, 64'h0102_0304_0506_0708, 1'b0, 0, 1'b0, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
